evdb_ctrl: RTL and testbench

EVDB_CTRL -- requirements
Module: evdb_ctrl

---
 rtl/evdb_ctrl.sv | 171 +++++++++++++++++
 tb/tb_evdb_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/evdb_ctrl.sv
// Evict-data-buffer controller: hands out 4-beat buffer groups, tracks their fill,
// and streams a filled group downstream one beat at a time from the buffer RAM.
module evdb_ctrl #(
  parameter int GRP_NUM = 8,
  parameter int GRP_W   = 3,
  parameter int DATA_W  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  // allocation
  output logic                alloc_vld,
  output logic [GRP_W-1:0]    alloc_idx,
  input  logic                alloc_rdy,
  // SRAM read data landing in the buffer
  input  logic                fill_vld,
  input  logic [GRP_W-1:0]    fill_idx,
  input  logic [1:0]          fill_beat,
  // drain request
  input  logic                drain_vld,
  input  logic [GRP_W-1:0]    drain_idx,
  output logic                drain_rdy,
  // buffer RAM
  output logic                mem_en,
  output logic                mem_wr,
  output logic [GRP_W+1:0]    mem_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  // downstream
  output logic                ds_vld,
  input  logic                ds_rdy,
  output logic [DATA_W-1:0]   ds_data,
  output logic [GRP_W-1:0]    ds_idx,
  output logic [1:0]          ds_beat,
  output logic                ds_last,
  // status
  output logic                release_vld,
  output logic [GRP_W-1:0]    release_idx,
  output logic [GRP_W:0]      free_cnt,
  output logic                err,
  output logic [1:0]          drain_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and fill has no ready at all (it always lands).

  typedef enum logic [1:0] {G_FREE, G_ALLOC, G_FULL, G_DRAIN} grp_st_t;
  typedef enum logic [1:0] {D_IDLE, D_RD, D_OUT} drn_st_t;

  grp_st_t           grp_st   [GRP_NUM];
  logic [1:0]        fill_cnt [GRP_NUM];

  drn_st_t           d_st, d_nxt;
  logic [GRP_W-1:0]  grp_q;
  logic [1:0]        beat_q;
  logic              out_first;
  logic [DATA_W-1:0] ds_data_q;

  logic alloc_fire, fill_ok, drain_fire, rd_issue, ds_fire, last_fire;

  // lowest-index FREE group from the registered state
  always_comb begin
    alloc_vld = 1'b0;
    alloc_idx = '0;
    for (int i = GRP_NUM - 1; i >= 0; i--) begin
      if (grp_st[i] == G_FREE) begin
        alloc_vld = 1'b1;
        alloc_idx = GRP_W'(i);
      end
    end
  end

  assign alloc_fire = alloc_vld && alloc_rdy;
  assign fill_ok    = fill_vld && (grp_st[fill_idx] == G_ALLOC);
  assign drain_rdy  = (d_st == D_IDLE) && (grp_st[drain_idx] == G_FULL);
  assign drain_fire = drain_vld && drain_rdy;
  assign rd_issue   = (d_st == D_RD) && !fill_vld;
  assign ds_fire    = (d_st == D_OUT) && ds_rdy;
  assign last_fire  = ds_fire && (beat_q == 2'd3);

  // Fill writes always win the single RAM port; the drain read waits in RD.
  always_comb begin
    mem_en   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    if (fill_vld) begin
      mem_en   = 1'b1;
      mem_wr   = 1'b1;
      mem_addr = {fill_idx, fill_beat};
    end else if (d_st == D_RD) begin
      mem_en   = 1'b1;
      mem_addr = {grp_q, beat_q};
    end
  end

  always_comb begin
    d_nxt = d_st;
    case (d_st)
      D_IDLE:  if (drain_fire) d_nxt = D_RD;
      D_RD:    if (rd_issue) d_nxt = D_OUT;
      D_OUT:   if (ds_fire) d_nxt = last_fire ? D_IDLE : D_RD;
      default: d_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_st <= D_IDLE;
    else        d_st <= d_nxt;
  end

  assign drain_state = d_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < GRP_NUM; g++) begin
        grp_st[g]   <= G_FREE;
        fill_cnt[g] <= '0;
      end
    end else begin
      for (int g = 0; g < GRP_NUM; g++) begin
        if (alloc_fire && alloc_idx == GRP_W'(g)) begin
          grp_st[g]   <= G_ALLOC;
          fill_cnt[g] <= '0;
        end else if (fill_ok && fill_idx == GRP_W'(g)) begin
          fill_cnt[g] <= 2'(fill_cnt[g] + 2'd1);
          if (fill_beat == 2'd3) grp_st[g] <= G_FULL;
        end else if (drain_fire && drain_idx == GRP_W'(g)) begin
          grp_st[g] <= G_DRAIN;
        end else if (last_fire && grp_q == GRP_W'(g)) begin
          grp_st[g] <= G_FREE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q       <= '0;
      beat_q      <= '0;
      out_first   <= 1'b0;
      ds_data_q   <= '0;
      release_vld <= 1'b0;
      release_idx <= '0;
      err         <= 1'b0;
      free_cnt    <= (GRP_W+1)'(GRP_NUM);
    end else begin
      if (drain_fire) begin
        grp_q  <= drain_idx;
        beat_q <= '0;
      end else if (ds_fire && !last_fire) begin
        beat_q <= 2'(beat_q + 2'd1);
      end
      // RAM data is valid only in the first OUT cycle; hold it for the rest of OUT
      out_first <= rd_issue;
      if (out_first) ds_data_q <= mem_rd_data;
      release_vld <= last_fire;
      if (last_fire) release_idx <= grp_q;
      if (fill_vld && !fill_ok) err <= 1'b1;
      case ({alloc_fire, last_fire})
        2'b10:   free_cnt <= free_cnt - 1'b1;
        2'b01:   free_cnt <= free_cnt + 1'b1;
        default: free_cnt <= free_cnt;
      endcase
    end
  end

  assign ds_vld  = (d_st == D_OUT);
  assign ds_data = out_first ? mem_rd_data : ds_data_q;
  assign ds_idx  = grp_q;
  assign ds_beat = beat_q;
  assign ds_last = (beat_q == 2'd3);

endmodule

// File: tb/tb_evdb_ctrl.sv
// Bench for evdb_ctrl: behavioural buffer RAM, directed traffic, and a
// scoreboard of expected downstream beats checked on every ds handshake.
module tb_evdb_ctrl;
  localparam int GRP_NUM = 8;
  localparam int GRP_W   = 3;
  localparam int DATA_W  = 64;
  localparam int AW      = GRP_W + 2;
  localparam int SB_W    = DATA_W + GRP_W + 3;

  logic              clk, rst_n;
  logic              alloc_vld, alloc_rdy;
  logic [GRP_W-1:0]  alloc_idx;
  logic              fill_vld;
  logic [GRP_W-1:0]  fill_idx;
  logic [1:0]        fill_beat;
  logic              drain_vld, drain_rdy;
  logic [GRP_W-1:0]  drain_idx;
  logic              mem_en, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              ds_vld, ds_rdy, ds_last;
  logic [DATA_W-1:0] ds_data;
  logic [GRP_W-1:0]  ds_idx;
  logic [1:0]        ds_beat;
  logic              release_vld;
  logic [GRP_W-1:0]  release_idx;
  logic [GRP_W:0]    free_cnt;
  logic              err;
  logic [1:0]        drain_state;

  evdb_ctrl #(.GRP_NUM(GRP_NUM), .GRP_W(GRP_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_vld(alloc_vld), .alloc_idx(alloc_idx), .alloc_rdy(alloc_rdy),
    .fill_vld(fill_vld), .fill_idx(fill_idx), .fill_beat(fill_beat),
    .drain_vld(drain_vld), .drain_idx(drain_idx), .drain_rdy(drain_rdy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .ds_vld(ds_vld), .ds_rdy(ds_rdy), .ds_data(ds_data), .ds_idx(ds_idx),
    .ds_beat(ds_beat), .ds_last(ds_last),
    .release_vld(release_vld), .release_idx(release_idx),
    .free_cnt(free_cnt), .err(err), .drain_state(drain_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // behavioural RAM: 1-cycle read latency, garbage on the read port otherwise
  logic [DATA_W-1:0] ram     [32];
  logic [DATA_W-1:0] ram_exp [32];
  logic [DATA_W-1:0] fill_data;

  always @(posedge clk) begin
    if (mem_en && mem_wr) ram[mem_addr] <= fill_data;
    if (mem_en && !mem_wr) mem_rd_data <= ram[mem_addr];
    else                   mem_rd_data <= {$urandom, $urandom};
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ds_vld && ds_rdy) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("ds_beat", {ds_idx, ds_beat, ds_last, ds_data}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    rst_n = 1'b0;
    #1;
    check("rst_free_cnt", free_cnt, GRP_NUM);
    check("rst_alloc_vld", alloc_vld, 1);
    check("rst_alloc_idx", alloc_idx, 0);
    check("rst_ds_vld", ds_vld, 0);
    check("rst_ds_data", ds_data, 0);
    check("rst_release", release_vld, 0);
    check("rst_err", err, 0);
    check("rst_drain_rdy", drain_rdy, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc_one(input int exp_idx);
    alloc_rdy = 1'b1;
    #1;
    check("alloc_vld", alloc_vld, 1);
    check("alloc_idx", alloc_idx, exp_idx);
    tick();
    alloc_rdy = 1'b0;
  endtask

  task automatic fill(input int idx, input int beat);
    logic [AW-1:0] a;
    a = {GRP_W'(idx), 2'(beat)};
    fill_vld  = 1'b1;
    fill_idx  = GRP_W'(idx);
    fill_beat = 2'(beat);
    fill_data = {$urandom, $urandom};
    ram_exp[a] = fill_data;
    #1;
    check("fill_wr", {mem_en, mem_wr}, 2'b11);
    check("fill_addr", mem_addr, a);
    tick();
    fill_vld = 1'b0;
  endtask

  task automatic drain_req(input int idx);
    logic [AW-1:0] a;
    drain_vld = 1'b1;
    drain_idx = GRP_W'(idx);
    #1;
    check("drain_rdy", drain_rdy, 1);
    for (int b = 0; b < 4; b++) begin
      a = {GRP_W'(idx), 2'(b)};
      exp_q.push_back({GRP_W'(idx), 2'(b), (b == 3), ram_exp[a]});
    end
    tick();
    drain_vld = 1'b0;
  endtask

  task automatic wait_release(input int idx, input int exp_free);
    int seen;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      if (release_vld) seen = 1;
      else tick();
    end
    check("release_seen", seen, 1);
    check("release_idx", release_idx, idx);
    check("release_free_cnt", free_cnt, exp_free);
  endtask

  initial begin
    rst_n = 1'b0; alloc_rdy = 1'b0; fill_vld = 1'b0; fill_idx = '0; fill_beat = '0;
    drain_vld = 1'b0; drain_idx = '0; ds_rdy = 1'b0; fill_data = '0;
    for (int i = 0; i < 32; i++) ram_exp[i] = '0;
    tick();
    reset_check();

    // allocate every group in index order
    alloc_rdy = 1'b1;
    for (int i = 0; i < GRP_NUM; i++) begin
      check("seq_alloc_vld", alloc_vld, 1);
      check("seq_alloc_idx", alloc_idx, i);
      check("seq_free_cnt", free_cnt, GRP_NUM - i);
      tick();
    end
    check("exhausted_vld", alloc_vld, 0);
    check("exhausted_cnt", free_cnt, 0);
    alloc_rdy = 1'b0;
    reset_check();

    // fill group 2 and drain it with ds_rdy held high
    alloc_one(0); alloc_one(1); alloc_one(2);
    check("after_alloc_cnt", free_cnt, 5);
    for (int b = 0; b < 4; b++) fill(2, b);
    check("full_no_err", err, 0);
    ds_rdy = 1'b1;
    drain_req(2);
    check("lat_rd_cycle", ds_vld, 0);
    tick();
    check("lat_first_vld", ds_vld, 1);
    check("lat_first_beat", ds_beat, 0);
    for (int c = 0; c < 6; c++) tick();
    check("no_early_release", release_vld, 0);
    tick();
    check("release_pulse", release_vld, 1);
    check("release_idx2", release_idx, 2);
    check("free_after_rel", free_cnt, 6);
    tick();
    check("release_one_cycle", release_vld, 0);

    // fill to a FREE group: write still issued, error flagged, no state change
    fill(5, 1);
    check("err_set", err, 1);
    check("err_free_cnt", free_cnt, 6);
    check("err_alloc_idx", alloc_idx, 2);
    tick(); tick();
    check("err_sticky", err, 1);

    // write priority over RD, then hold OUT under fill traffic
    alloc_one(2);
    for (int b = 0; b < 4; b++) fill(2, b);
    ds_rdy = 1'b0;
    drain_req(2);
    for (int b = 0; b < 3; b++) begin
      fill(1, b);
      check("rd_held", ds_vld, 0);
    end
    #1;
    check("rd_issue", {mem_en, mem_wr}, 2'b10);
    check("rd_addr", mem_addr, {3'd2, 2'd0});
    tick();
    check("out_vld", ds_vld, 1);
    for (int c = 0; c < 5; c++) begin
      if (c < 4) fill(0, c);
      else       fill(1, 3);
      check("stall_data", ds_data, ram_exp[{3'd2, 2'd0}]);
      check("stall_beat_idx", {ds_idx, ds_beat, ds_vld}, {3'd2, 2'd0, 1'b1});
    end
    ds_rdy = 1'b1;
    wait_release(2, 6);
    tick();
    check("sb_empty", exp_q.size(), 0);

    // reset while streaming beat 2 of group 0
    drain_req(0);
    for (int c = 0; c < 5; c++) tick();
    check("pre_rst_beat", {ds_vld, ds_beat}, {1'b1, 2'd2});
    reset_check();
    for (int c = 0; c < 4; c++) begin
      check("no_release_after_rst", release_vld, 0);
      tick();
    end
    check("post_rst_free", free_cnt, GRP_NUM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
